alu_core: RTL and testbench

Arithmetic/logic unit for the 8051 core and the producer side of the PSW flag interface. It computes the accumulator-class operations and emits `carry_out`, `aux_carry_out`, `overflow_out` and a `flag_set` code, which the PSW register consumes unchanged. Single-cycle operations complete in one clock. MUL AB and DIV AB run as an 8-iteration sequential engine with a start/busy/done handshake.

---
 rtl/alu_core_pkg.sv | 29 ++
 rtl/alu_muldiv_seq.sv | 93 +++++++++
 rtl/alu_core.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// alu_core_pkg: shared opcode and flag-update encodings for the 8051 ALU.
// The PSW register decodes the same flag_set codes, so they must not change.
package alu_core_pkg;

    // ALU opcodes (op input of alu_core)
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDC = 4'h1;
    localparam logic [3:0] ALU_SUBB = 4'h2;
    localparam logic [3:0] ALU_INC  = 4'h3;
    localparam logic [3:0] ALU_DEC  = 4'h4;
    localparam logic [3:0] ALU_ANL  = 4'h5;
    localparam logic [3:0] ALU_ORL  = 4'h6;
    localparam logic [3:0] ALU_XRL  = 4'h7;
    localparam logic [3:0] ALU_CPL  = 4'h8;
    localparam logic [3:0] ALU_RL   = 4'h9;
    localparam logic [3:0] ALU_RLC  = 4'hA;
    localparam logic [3:0] ALU_RR   = 4'hB;
    localparam logic [3:0] ALU_RRC  = 4'hC;
    localparam logic [3:0] ALU_DA   = 4'hD;
    localparam logic [3:0] ALU_MUL  = 4'hE;
    localparam logic [3:0] ALU_DIV  = 4'hF;

    // flag_set codes consumed by the PSW register
    localparam logic [1:0] FLAG_NONE    = 2'd0;
    localparam logic [1:0] CY_SET       = 2'd1;
    localparam logic [1:0] CY_OV_SET    = 2'd2;
    localparam logic [1:0] CY_OV_AC_SET = 2'd3;

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 8-iteration shift-add multiplier / restoring divider.
// Only compiled when ALU_MULDIV_EN is defined.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   load_i                latch operands and restart the iteration counter
//   run_i                 iterate while high (owner FSM is in CALC)
//   is_div_i              1: divide a_i by b_i, 0: multiply
//   a_i, b_i              operands
//   fin_o                 all 8 iterations done; acc_o is final
//   is_div_o              latched operation kind
//   acc_o                 MUL: {hi, lo} product; DIV: {remainder, quotient}
`ifdef ALU_MULDIV_EN
module alu_muldiv_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        run_i,
    input  logic        is_div_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        fin_o,
    output logic        is_div_o,
    output logic [15:0] acc_o
);

    logic [15:0] acc_q, acc_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        fin_q, fin_d;
    logic        is_div_q, is_div_d;

    logic [8:0]  mul_sum;
    logic [8:0]  div_trial;
    logic [7:0]  div_diff;
    logic        div_ok;

    // MUL: upper byte accumulates the multiplicand when the LSB of the
    // multiplier (acc low byte) is set, then the whole word shifts right.
    assign mul_sum   = {1'b0, acc_q[15:8]} + (acc_q[0] ? {1'b0, b_q} : 9'd0);
    // DIV: {remainder, quotient} shifts left; the 9-bit window is the trial
    // remainder, restored (left unchanged) when it is below the divisor.
    assign div_trial = acc_q[15:7];
    assign div_ok    = (div_trial >= {1'b0, b_q});
    assign div_diff  = div_trial[7:0] - b_q;

    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        is_div_d = is_div_q;
        if (load_i) begin
            acc_d    = {8'h00, a_i};
            b_d      = b_i;
            is_div_d = is_div_i;
            cnt_d    = 3'd0;
            fin_d    = 1'b0;
        end else if (run_i && !fin_q) begin
            if (is_div_q) begin
                acc_d = div_ok ? {div_diff, acc_q[6:0], 1'b1}
                               : {div_trial[7:0], acc_q[6:0], 1'b0};
            end else begin
                acc_d = {mul_sum, acc_q[7:1]};
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                fin_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= 16'h0000;
            b_q      <= 8'h00;
            cnt_q    <= 3'd0;
            fin_q    <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
            is_div_q <= is_div_d;
        end
    end

    assign fin_o    = fin_q;
    assign is_div_o = is_div_q;
    assign acc_o    = acc_q;

endmodule
`endif

// File: rtl/alu_core.sv
// alu_core: 8051 accumulator ALU and producer of PSW flag updates.
// Single-cycle ops finish one clock after start; MUL/DIV use alu_muldiv_seq
// when ALU_MULDIV_EN is defined, otherwise they pass src1 through.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   start, op, src1, src2        launch request, opcode, operands
//   carry_in, aux_carry_in       current PSW.CY / PSW.AC
//   busy                         MUL/DIV iterating
//   done                         one-cycle pulse, results/flags valid
//   result, result_hi            A and B results
//   carry_out, aux_carry_out,
//   overflow_out, flag_set       flags and update code for the PSW
module alu_core
    import alu_core_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] src1,
    input  logic [7:0] src2,
    input  logic       carry_in,
    input  logic       aux_carry_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] result_hi,
    output logic       carry_out,
    output logic       aux_carry_out,
    output logic       overflow_out,
    output logic [1:0] flag_set
);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`else
    typedef enum logic {StIdle, StDone} state_e;
`endif

    state_e     state_q, state_d;
    logic [7:0] result_q, result_d;
    logic [7:0] hi_q, hi_d;
    logic       cy_q, cy_d;
    logic       ac_q, ac_d;
    logic       ov_q, ov_d;
    logic [1:0] flag_q, flag_d;

    logic [7:0] alu_res, alu_hi;
    logic       alu_cy, alu_ac, alu_ov;
    logic [1:0] alu_flag;

    // ADD/ADDC/SUBB share one datapath; partial sums give the bit-3 and
    // bit-6 carries/borrows needed for AC and OV.
    logic       arith_sub, arith_cin;
    logic [4:0] arith_nib;
    logic [7:0] arith7;
    logic [8:0] arith9;

    assign arith_sub = (op == ALU_SUBB);
    assign arith_cin = (op != ALU_ADD) & carry_in;
    assign arith_nib = arith_sub
        ? ({1'b0, src1[3:0]} - {1'b0, src2[3:0]} - {4'b0, arith_cin})
        : ({1'b0, src1[3:0]} + {1'b0, src2[3:0]} + {4'b0, arith_cin});
    assign arith7 = arith_sub
        ? ({1'b0, src1[6:0]} - {1'b0, src2[6:0]} - {7'b0, arith_cin})
        : ({1'b0, src1[6:0]} + {1'b0, src2[6:0]} + {7'b0, arith_cin});
    assign arith9 = arith_sub
        ? ({1'b0, src1} - {1'b0, src2} - {8'b0, arith_cin})
        : ({1'b0, src1} + {1'b0, src2} + {8'b0, arith_cin});

    // Decimal adjust: the high-nibble test sees the low-adjusted value and
    // any carry it produced; CY is only ever set, never cleared.
    logic       da_lo_adj, da_hi_adj;
    logic [8:0] da_t1, da_t2;

    assign da_lo_adj = (src1[3:0] > 4'd9) || aux_carry_in;
    assign da_t1     = {1'b0, src1} + (da_lo_adj ? 9'h006 : 9'h000);
    assign da_hi_adj = (da_t1[7:4] > 4'd9) || carry_in || da_t1[8];
    assign da_t2     = {1'b0, da_t1[7:0]} + (da_hi_adj ? 9'h060 : 9'h000);

`ifdef ALU_MULDIV_EN
    logic        alu_go_calc;
    logic        seq_load, seq_fin, seq_is_div;
    logic [15:0] seq_acc;

    alu_muldiv_seq u_muldiv_seq (
        .clk_i    (clock),
        .rst_i    (reset),
        .load_i   (seq_load),
        .run_i    (state_q == StCalc),
        .is_div_i (op == ALU_DIV),
        .a_i      (src1),
        .b_i      (src2),
        .fin_o    (seq_fin),
        .is_div_o (seq_is_div),
        .acc_o    (seq_acc)
    );
`endif

    // Single-cycle results; flags an op does not touch keep their value.
    always_comb begin
        alu_res  = src1;
        alu_hi   = 8'h00;
        alu_cy   = cy_q;
        alu_ac   = ac_q;
        alu_ov   = ov_q;
        alu_flag = FLAG_NONE;
`ifdef ALU_MULDIV_EN
        alu_go_calc = 1'b0;
`endif
        case (op)
            ALU_ADD, ALU_ADDC, ALU_SUBB: begin
                alu_res  = arith9[7:0];
                alu_cy   = arith9[8];
                alu_ac   = arith_nib[4];
                alu_ov   = arith7[7] ^ arith9[8];
                alu_flag = CY_OV_AC_SET;
            end
            ALU_INC: alu_res = src1 + 8'd1;
            ALU_DEC: alu_res = src1 - 8'd1;
            ALU_ANL: alu_res = src1 & src2;
            ALU_ORL: alu_res = src1 | src2;
            ALU_XRL: alu_res = src1 ^ src2;
            ALU_CPL: alu_res = ~src1;
            ALU_RL:  alu_res = {src1[6:0], src1[7]};
            ALU_RR:  alu_res = {src1[0], src1[7:1]};
            ALU_RLC: begin
                alu_res  = {src1[6:0], carry_in};
                alu_cy   = src1[7];
                alu_flag = CY_SET;
            end
            ALU_RRC: begin
                alu_res  = {carry_in, src1[7:1]};
                alu_cy   = src1[0];
                alu_flag = CY_SET;
            end
            ALU_DA: begin
                alu_res  = da_t2[7:0];
                alu_cy   = carry_in | da_t1[8] | da_t2[8];
                alu_flag = CY_SET;
            end
`ifdef ALU_MULDIV_EN
            ALU_MUL, ALU_DIV: begin
                if ((op == ALU_DIV) && (src2 == 8'h00)) begin
                    alu_res  = 8'hFF;
                    alu_hi   = src1;
                    alu_cy   = 1'b0;
                    alu_ov   = 1'b1;
                    alu_flag = CY_OV_SET;
                end else begin
                    alu_go_calc = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Next-state and output registers. IDLE and DONE both accept start,
    // which gives back-to-back issue from the done cycle.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        cy_d     = cy_q;
        ac_d     = ac_q;
        ov_d     = ov_q;
        flag_d   = FLAG_NONE;
`ifdef ALU_MULDIV_EN
        seq_load = 1'b0;
        if (state_q == StCalc) begin
            if (seq_fin) begin
                state_d  = StDone;
                result_d = seq_acc[7:0];
                hi_d     = seq_acc[15:8];
                cy_d     = 1'b0;
                ov_d     = seq_is_div ? 1'b0 : (seq_acc[15:8] != 8'h00);
                flag_d   = CY_OV_SET;
            end
        end else
`endif
        begin
            state_d = StIdle;
            if (start) begin
`ifdef ALU_MULDIV_EN
                if (alu_go_calc) begin
                    state_d  = StCalc;
                    seq_load = 1'b1;
                end else
`endif
                begin
                    state_d  = StDone;
                    result_d = alu_res;
                    hi_d     = alu_hi;
                    cy_d     = alu_cy;
                    ac_d     = alu_ac;
                    ov_d     = alu_ov;
                    flag_d   = alu_flag;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= 8'h00;
            hi_q     <= 8'h00;
            cy_q     <= 1'b0;
            ac_q     <= 1'b0;
            ov_q     <= 1'b0;
            flag_q   <= FLAG_NONE;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            cy_q     <= cy_d;
            ac_q     <= ac_d;
            ov_q     <= ov_d;
            flag_q   <= flag_d;
        end
    end

`ifdef ALU_MULDIV_EN
    assign busy = (state_q == StCalc);
`else
    assign busy = 1'b0;
`endif
    assign done          = (state_q == StDone);
    assign result        = result_q;
    assign result_hi     = hi_q;
    assign carry_out     = cy_q;
    assign aux_carry_out = ac_q;
    assign overflow_out  = ov_q;
    assign flag_set      = flag_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed self-checking bench for alu_core.
// MUL/DIV sections follow ALU_MULDIV_EN in the same way as the design.
module tb_alu_core;
    import alu_core_pkg::*;

    logic       clock, reset, start, carry_in, aux_carry_in;
    logic [3:0] op;
    logic [7:0] src1, src2;
    logic       busy, done, carry_out, aux_carry_out, overflow_out;
    logic [7:0] result, result_hi;
    logic [1:0] flag_set;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    alu_core dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .src1          (src1),
        .src2          (src2),
        .carry_in      (carry_in),
        .aux_carry_in  (aux_carry_in),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .result_hi     (result_hi),
        .carry_out     (carry_out),
        .aux_carry_out (aux_carry_out),
        .overflow_out  (overflow_out),
        .flag_set      (flag_set)
    );

`define CHK(tag, obs, exp) \
    begin \
        n_checks++; \
        assert ((obs) === (exp)) else begin \
            n_errors++; \
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp); \
        end \
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present an op for one edge; returns #1 after that edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic ai);
        op = o;
        src1 = a;
        src2 = b;
        carry_in = ci;
        aux_carry_in = ai;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Report a wait that ran out before done was seen.
    task automatic check_wait(input string tag, input logic seen);
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++;
            $error("FAIL %s: wait for done expired", tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = 4'h0;
        src1 = 8'h00;
        src2 = 8'h00;
        carry_in = 1'b0;
        aux_carry_in = 1'b0;
        #2;
        n_checks++;
        if ({result, result_hi, carry_out, aux_carry_out, overflow_out, flag_set, done, busy}
            !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, FLAG_NONE, 1'b0, 1'b0}) begin
            n_errors++;
            $error("FAIL rst_state: outputs not at reset values");
        end
        `CHK("rst_result", result, 8'h00)
        `CHK("rst_hi", result_hi, 8'h00)
        `CHK("rst_cy", carry_out, 1'b0)
        `CHK("rst_ov", overflow_out, 1'b0)
        `CHK("rst_flag", flag_set, FLAG_NONE)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // ADD 7F + 01
        issue(ALU_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        `CHK("add_done", done, 1'b1)
        `CHK("add_res", result, 8'h80)
        `CHK("add_cy", carry_out, 1'b0)
        `CHK("add_ac", aux_carry_out, 1'b1)
        `CHK("add_ov", overflow_out, 1'b1)
        `CHK("add_flag", flag_set, CY_OV_AC_SET)
        @(posedge clock);
        #1;
        `CHK("add_done_low", done, 1'b0)
        `CHK("add_flag_none", flag_set, FLAG_NONE)
        `CHK("add_hold", result, 8'h80)

        // SUBB 00 - 01, no borrow in
        issue(ALU_SUBB, 8'h00, 8'h01, 1'b0, 1'b0);
        `CHK("subb_res", result, 8'hFF)
        `CHK("subb_cy", carry_out, 1'b1)
        `CHK("subb_ac", aux_carry_out, 1'b1)
        `CHK("subb_ov", overflow_out, 1'b0)

        // ADDC 0x3A + 0x05 + 1
        issue(ALU_ADDC, 8'h3A, 8'h05, 1'b1, 1'b0);
        `CHK("addc_res", result, 8'h40)
        `CHK("addc_ac", aux_carry_out, 1'b1)
        `CHK("addc_cy", carry_out, 1'b0)

        // DA 0x9B
        issue(ALU_DA, 8'h9B, 8'h00, 1'b0, 1'b0);
        `CHK("da_res", result, 8'h01)
        `CHK("da_cy", carry_out, 1'b1)
        `CHK("da_flag", flag_set, CY_SET)

        // RLC 0x81 then XRL issued from the done cycle
        issue(ALU_RLC, 8'h81, 8'h00, 1'b0, 1'b0);
        `CHK("rlc_res", result, 8'h02)
        `CHK("rlc_cy", carry_out, 1'b1)
        issue(ALU_XRL, 8'hA5, 8'hFF, 1'b0, 1'b0);
        `CHK("b2b_done", done, 1'b1)
        `CHK("xrl_res", result, 8'h5A)
        `CHK("xrl_flag", flag_set, FLAG_NONE)
        `CHK("xrl_hi", result_hi, 8'h00)

        // RR 0x01
        issue(ALU_RR, 8'h01, 8'h00, 1'b0, 1'b0);
        `CHK("rr_res", result, 8'h80)

`ifdef ALU_MULDIV_EN
        // MUL 0x50 * 0xA0 with a start while busy and input changes
        issue(ALU_MUL, 8'h50, 8'hA0, 1'b0, 1'b0);
        `CHK("mul_busy", busy, 1'b1)
        `CHK("mul_nodone", done, 1'b0)
        op = ALU_ADD;
        src1 = 8'h11;
        src2 = 8'h22;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_wait("mul_wait", done);
        `CHK("mul_latency", n, 9)
        `CHK("mul_res", result, 8'h00)
        `CHK("mul_hi", result_hi, 8'h32)
        `CHK("mul_ov", overflow_out, 1'b1)
        `CHK("mul_cy", carry_out, 1'b0)
        `CHK("mul_flag", flag_set, CY_OV_SET)
        `CHK("mul_busy_low", busy, 1'b0)
        @(posedge clock);
        #1;
        `CHK("mul_single_done", done, 1'b0)
        `CHK("mul_hold_hi", result_hi, 8'h32)

        // DIV 0xFB / 0x12
        issue(ALU_DIV, 8'hFB, 8'h12, 1'b1, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_wait("div_wait", done);
        `CHK("div_latency", n, 9)
        `CHK("div_res", result, 8'h0D)
        `CHK("div_hi", result_hi, 8'h11)
        `CHK("div_ov", overflow_out, 1'b0)
        `CHK("div_cy", carry_out, 1'b0)

        // DIV by zero
        issue(ALU_DIV, 8'h37, 8'h00, 1'b0, 1'b0);
        `CHK("div0_done", done, 1'b1)
        `CHK("div0_busy", busy, 1'b0)
        `CHK("div0_res", result, 8'hFF)
        `CHK("div0_hi", result_hi, 8'h37)
        `CHK("div0_ov", overflow_out, 1'b1)
        `CHK("div0_flag", flag_set, CY_OV_SET)

        // Reset in the 4th CALC cycle of a MUL
        issue(ALU_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        `CHK("mid_busy", busy, 1'b1)
        #2;
        reset = 1'b1;
        #1;
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_res", result, 8'h00)
        `CHK("mid_rst_hi", result_hi, 8'h00)
        `CHK("mid_rst_ov", overflow_out, 1'b0)
        `CHK("mid_rst_flag", flag_set, FLAG_NONE)
        @(posedge clock);
        #1;
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            if (done) n++;
            @(posedge clock);
            #1;
        end
        `CHK("mid_rst_no_done", n, 0)
`else
        // MUL/DIV engine absent: single-cycle pass-through
        issue(ALU_MUL, 8'h50, 8'hA0, 1'b0, 1'b0);
        `CHK("mul_off_done", done, 1'b1)
        `CHK("mul_off_busy", busy, 1'b0)
        `CHK("mul_off_res", result, 8'h50)
        `CHK("mul_off_hi", result_hi, 8'h00)
        `CHK("mul_off_flag", flag_set, FLAG_NONE)
        issue(ALU_DIV, 8'hFB, 8'h00, 1'b0, 1'b0);
        `CHK("div_off_res", result, 8'hFB)
        `CHK("div_off_flag", flag_set, FLAG_NONE)

        // Asynchronous reset between operations
        #2;
        reset = 1'b1;
        #1;
        `CHK("rst2_res", result, 8'h00)
        `CHK("rst2_done", done, 1'b0)
        @(posedge clock);
        #1;
        reset = 1'b0;
`endif

        // Fresh ADD after reset
        issue(ALU_ADD, 8'h12, 8'h34, 1'b0, 1'b0);
        `CHK("post_done", done, 1'b1)
        `CHK("post_res", result, 8'h46)
        `CHK("post_cy", carry_out, 1'b0)
        `CHK("post_ac", aux_carry_out, 1'b0)
        `CHK("post_flag", flag_set, CY_OV_AC_SET)

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
